// File: rtl/fpu_sequencer.sv
// FP issue/writeback controller: accepts one op from decode, resolves the rounding
// mode, launches the FPU, waits for completion under a timeout and writes back.
module fpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_funct7,
  input  logic [4:0] req_rs1,
  input  logic [4:0] req_rs2,
  input  logic [4:0] req_rd,
  input  logic [2:0] req_rm,
  input  logic [2:0] csr_frm,
  output logic [4:0] rf_rs1,
  output logic [4:0] rf_rs2,
  output logic [4:0] rf_rd,
  output logic       rf_wen,
  output logic       fpu_start,
  output logic [6:0] fpu_funct7,
  output logic [2:0] fpu_frm,
  input  logic       fpu_done,
  input  logic [4:0] fpu_flags,
  output logic [4:0] fflags,
  input  logic       fflags_clr,
  output logic       busy,
  output logic       op_done,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t      r_state;
  logic [6:0]  r_funct7;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [2:0]  r_frm;
  logic [4:0]  r_flags;
  logic [4:0]  r_fflags;
  logic [7:0]  r_cnt;

  logic [2:0]  w_rm_eff;
  logic        w_rm_bad;
  logic        w_cnt_last;
  logic [4:0]  w_fflags_next;

  always_comb begin
    w_rm_eff = (req_rm == 3'b111) ? csr_frm : req_rm;
    w_rm_bad = (w_rm_eff == 3'b101) || (w_rm_eff == 3'b110) || (w_rm_eff == 3'b111);
  end

  assign w_cnt_last = (({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES));

  // Clear and accumulate in the same cycle keeps only the newly reported flags.
  assign w_fflags_next = (fflags_clr ? '0 : r_fflags) |
                         ((r_state == S_WB) ? r_flags : '0);

  // Selects and operation fields come straight from the capture registers, so they
  // stay stable from ISSUE through EXEC without extra holding logic.
  assign rf_rs1     = r_rs1;
  assign rf_rs2     = r_rs2;
  assign rf_rd      = r_rd;
  assign fpu_funct7 = r_funct7;
  assign fpu_frm    = r_frm;
  assign fflags     = r_fflags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_funct7  <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_frm     <= '0;
      r_flags   <= '0;
      r_fflags  <= '0;
      r_cnt     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      fpu_start <= 1'b0;
      rf_wen    <= 1'b0;
      op_done   <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      rf_wen    <= 1'b0;
      op_done   <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
      r_fflags  <= w_fflags_next;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_rm_bad) begin
              illegal <= 1'b1;
            end else begin
              r_funct7  <= req_funct7;
              r_rs1     <= req_rs1;
              r_rs2     <= req_rs2;
              r_rd      <= req_rd;
              r_frm     <= w_rm_eff;
              r_state   <= S_ISSUE;
              fpu_start <= 1'b1;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_EXEC;
        end

        S_EXEC: begin
          if (fpu_done) begin
            r_flags <= fpu_flags;
            r_state <= S_WB;
            rf_wen  <= 1'b1;
            op_done <= 1'b1;
          end else if (w_cnt_last) begin
            timeout   <= 1'b1;
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_WB: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: handshake, rounding-mode resolution, sticky
// flags, timeout, mid-operation reset and back-to-back throughput.
module tb_fpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_funct7;
  logic [4:0] req_rs1;
  logic [4:0] req_rs2;
  logic [4:0] req_rd;
  logic [2:0] req_rm;
  logic [2:0] csr_frm;
  logic [4:0] rf_rs1;
  logic [4:0] rf_rs2;
  logic [4:0] rf_rd;
  logic       rf_wen;
  logic       fpu_start;
  logic [6:0] fpu_funct7;
  logic [2:0] fpu_frm;
  logic       fpu_done;
  logic [4:0] fpu_flags;
  logic [4:0] fflags;
  logic       fflags_clr;
  logic       busy;
  logic       op_done;
  logic       illegal;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  fpu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct7(req_funct7), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .req_rm(req_rm), .csr_frm(csr_frm),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_wen(rf_wen),
    .fpu_start(fpu_start), .fpu_funct7(fpu_funct7), .fpu_frm(fpu_frm),
    .fpu_done(fpu_done), .fpu_flags(fpu_flags),
    .fflags(fflags), .fflags_clr(fflags_clr),
    .busy(busy), .op_done(op_done), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one complete legal op; lat=1 means done in the first EXEC cycle.
  task automatic run_op(input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [2:0] rm, input int lat,
                        input logic [4:0] flags, input logic clr_in_wb);
    req_valid = 1'b1; req_funct7 = f7; req_rs1 = s1; req_rs2 = s2; req_rd = d; req_rm = rm;
    tick;
    req_valid = 1'b0;
    tick;
    repeat (lat - 1) tick;
    fpu_done = 1'b1; fpu_flags = flags;
    tick;
    fpu_done = 1'b0; fpu_flags = '0;
    fflags_clr = clr_in_wb;
    tick;
    fflags_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_funct7 = '0; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; req_rm = '0; csr_frm = '0; fpu_done = 1'b0; fpu_flags = '0; fflags_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL reset_fflags got=%b exp=00000", fflags); end
    checks++; if ({fpu_start, rf_wen, op_done, illegal, timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=00000", {fpu_start, rf_wen, op_done, illegal, timeout});
    end
    checks++; if ({rf_rs1, rf_rs2, rf_rd, fpu_funct7, fpu_frm} !== 25'b0) begin
      errors++; $display("FAIL reset_fields got=%h exp=0", {rf_rs1, rf_rs2, rf_rd, fpu_funct7, fpu_frm});
    end
  endtask

  task automatic test_basic;
    req_valid = 1'b1; req_funct7 = 7'h00; req_rs1 = 5'd3; req_rs2 = 5'd4; req_rd = 5'd5; req_rm = 3'b000;
    tick;
    req_valid = 1'b0;
    checks++; if (fpu_start !== 1'b1) begin errors++; $display("FAIL basic_start got=%b exp=1", fpu_start); end
    checks++; if (rf_rs1 !== 5'd3 || rf_rs2 !== 5'd4) begin
      errors++; $display("FAIL basic_sel got=%0d,%0d exp=3,4", rf_rs1, rf_rs2);
    end
    checks++; if (fpu_frm !== 3'b000) begin errors++; $display("FAIL basic_frm got=%b exp=000", fpu_frm); end
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy got ready=%b busy=%b exp ready=0 busy=1", req_ready, busy);
    end
    tick;
    checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL basic_start_pulse got=%b exp=0", fpu_start); end
    fpu_done = 1'b1; fpu_flags = 5'b00001;
    tick;
    fpu_done = 1'b0; fpu_flags = '0;
    checks++; if (rf_wen !== 1'b1 || op_done !== 1'b1) begin
      errors++; $display("FAIL basic_wb got wen=%b done=%b exp 1,1", rf_wen, op_done);
    end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL basic_rd got=%0d exp=5", rf_rd); end
    tick;
    checks++; if (rf_wen !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL basic_return got wen=%b ready=%b exp 0,1", rf_wen, req_ready);
    end
    checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL basic_fflags got=%b exp=00001", fflags); end
  endtask

  task automatic test_dynamic_rm;
    req_valid = 1'b1; req_funct7 = 7'h01; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd6;
    req_rm = 3'b111; csr_frm = 3'b010;
    tick;
    req_valid = 1'b0;
    checks++; if (fpu_start !== 1'b1 || fpu_frm !== 3'b010) begin
      errors++; $display("FAIL dyn_frm got start=%b frm=%b exp 1,010", fpu_start, fpu_frm);
    end
    checks++; if (fpu_funct7 !== 7'h01) begin errors++; $display("FAIL dyn_funct7 got=%h exp=01", fpu_funct7); end
    csr_frm = 3'b011;
    tick;
    checks++; if (fpu_frm !== 3'b010) begin errors++; $display("FAIL dyn_frm_held got=%b exp=010", fpu_frm); end
    fpu_done = 1'b1; fpu_flags = 5'b00000;
    tick;
    fpu_done = 1'b0;
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd6) begin
      errors++; $display("FAIL dyn_wb got wen=%b rd=%0d exp 1,6", rf_wen, rf_rd);
    end
    tick;

    req_valid = 1'b1; req_rm = 3'b111; csr_frm = 3'b101;
    tick;
    checks++; if (illegal !== 1'b1 || fpu_start !== 1'b0) begin
      errors++; $display("FAIL illegal_dyn got ill=%b start=%b exp 1,0", illegal, fpu_start);
    end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_ready got ready=%b busy=%b exp 1,0", req_ready, busy);
    end
    req_rm = 3'b110;
    tick;
    checks++; if (illegal !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_static got ill=%b busy=%b exp 1,0", illegal, busy);
    end
    req_rm = 3'b000;
    tick;
    req_valid = 1'b0;
    checks++; if (illegal !== 1'b0 || fpu_start !== 1'b1) begin
      errors++; $display("FAIL illegal_then_accept got ill=%b start=%b exp 0,1", illegal, fpu_start);
    end
    tick;
    fpu_done = 1'b1; fpu_flags = 5'b00000;
    tick;
    fpu_done = 1'b0;
    tick;
    checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL illegal_fflags got=%b exp=00001", fflags); end
  endtask

  task automatic test_flags_accum;
    fflags_clr = 1'b1;
    tick;
    fflags_clr = 1'b0;
    checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL flags_clear got=%b exp=00000", fflags); end
    run_op(7'h02, 5'd7, 5'd8, 5'd9, 3'b001, 1, 5'b10000, 1'b0);
    run_op(7'h03, 5'd10, 5'd11, 5'd12, 3'b100, 2, 5'b00100, 1'b0);
    checks++; if (fflags !== 5'b10100) begin errors++; $display("FAIL flags_accum got=%b exp=10100", fflags); end
    run_op(7'h04, 5'd13, 5'd14, 5'd15, 3'b011, 1, 5'b01000, 1'b1);
    checks++; if (fflags !== 5'b01000) begin errors++; $display("FAIL flags_clr_wb got=%b exp=01000", fflags); end
  endtask

  task automatic test_timeout;
    int wen_seen;
    wen_seen = 0;
    req_valid = 1'b1; req_rm = 3'b000; req_rd = 5'd20;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (rf_wen === 1'b1) wen_seen++;
      checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL timeout_early exec=%0d got to=%b busy=%b exp 0,1", i + 1, timeout, busy);
      end
    end
    tick;
    checks++; if (timeout !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse got to=%b ready=%b busy=%b exp 1,1,0", timeout, req_ready, busy);
    end
    if (rf_wen === 1'b1) wen_seen++;
    checks++; if (wen_seen !== 0) begin errors++; $display("FAIL timeout_nowrite got=%0d exp=0", wen_seen); end
    tick;
    checks++; if (timeout !== 1'b0 || fflags !== 5'b01000) begin
      errors++; $display("FAIL timeout_after got to=%b fflags=%b exp 0,01000", timeout, fflags);
    end
  endtask

  task automatic test_reset_midop;
    req_valid = 1'b1; req_rm = 3'b000; req_rd = 5'd21;
    tick;
    req_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || fflags !== 5'b0) begin
      errors++; $display("FAIL rst_async got busy=%b ready=%b fflags=%b exp 0,1,00000", busy, req_ready, fflags);
    end
    checks++; if ({rf_rd, fpu_frm, fpu_start, rf_wen} !== 10'b0) begin
      errors++; $display("FAIL rst_outputs got=%b exp=0", {rf_rd, fpu_frm, fpu_start, rf_wen});
    end
    tick;
    rst = 1'b0;
    fpu_done = 1'b1; fpu_flags = 5'b11111;
    tick;
    tick;
    fpu_done = 1'b0; fpu_flags = '0;
    checks++; if (rf_wen !== 1'b0 || op_done !== 1'b0 || busy !== 1'b0 || fflags !== 5'b0) begin
      errors++; $display("FAIL rst_stray_done got wen=%b done=%b busy=%b fflags=%b exp 0,0,0,00000",
                         rf_wen, op_done, busy, fflags);
    end
    run_op(7'h05, 5'd16, 5'd17, 5'd18, 3'b010, 1, 5'b00010, 1'b0);
    checks++; if (fflags !== 5'b00010 || rf_rd !== 5'd18) begin
      errors++; $display("FAIL rst_recover got fflags=%b rd=%0d exp 00010,18", fflags, rf_rd);
    end
  endtask

  task automatic test_back_to_back;
    int accepts;
    accepts = 0;
    req_valid = 1'b1; req_rm = 3'b001; req_rd = 5'd22;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (fpu_start === 1'b1) accepts++;
      checks++; if (fpu_start !== ((i - 1) % 5 == 0)) begin
        errors++; $display("FAIL b2b_start cyc=%0d got=%b exp=%b", i, fpu_start, ((i - 1) % 5 == 0));
      end
      checks++; if (req_ready !== ((i - 1) % 5 == 4)) begin
        errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, req_ready, ((i - 1) % 5 == 4));
      end
      checks++; if (rf_wen !== ((i - 1) % 5 == 3)) begin
        errors++; $display("FAIL b2b_wen cyc=%0d got=%b exp=%b", i, rf_wen, ((i - 1) % 5 == 3));
      end
      fpu_done  = ((i - 1) % 5 == 2);
      fpu_flags = 5'b00000;
    end
    req_valid = 1'b0;
    fpu_done  = 1'b0;
    checks++; if (accepts !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", accepts); end
    tick;
    checks++; if (busy !== 1'b0 || fpu_start !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got busy=%b start=%b exp 0,0", busy, fpu_start);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_dynamic_rm;
    test_flags_accum;
    test_timeout;
    test_reset_midop;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
